// File: rtl/script_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// script_loader_if
// UART byte stream into the script loader, plus the instruction read port
// and load status seen by the executor.
// Rev 1.0
// ---------------------------------------------------------------------------
interface script_loader_if #(
    parameter int LEN_BYTES   = 1,
    parameter int INSTR_BYTES = 2
);
    logic [7:0]               dataOut_bits;
    logic                     dataOut_valid;
    logic [8*LEN_BYTES-1:0]   pc;
    logic [8*INSTR_BYTES-1:0] script;
    logic                     script_mode;
    logic                     script_ready;
    logic                     load_error;
    logic [8*LEN_BYTES-1:0]   script_num;

    modport master (
        output dataOut_bits, dataOut_valid, pc,
        input  script, script_mode, script_ready, load_error, script_num
    );

    modport slave (
        input  dataOut_bits, dataOut_valid, pc,
        output script, script_mode, script_ready, load_error, script_num
    );
endinterface
`default_nettype wire

// File: rtl/script_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// script_loader
// Receives a length/checksum framed script from the UART byte stream into a
// byte memory and serves INSTR_BYTES-wide instructions at pc.
// Rev 1.0
// ---------------------------------------------------------------------------
module script_loader #(
    parameter int DEPTH          = 255,
    parameter int LEN_BYTES      = 1,
    parameter int INSTR_BYTES    = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input wire             clock,
    input wire             reset_n,
    script_loader_if.slave bus
);
    localparam int c_AW = 8 * LEN_BYTES;
    localparam int c_MW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_LW = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_LOAD = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [c_AW-1:0]          r_size;
    logic [c_AW-1:0]          r_cnt;
    logic [c_AW-1:0]          r_num;
    logic [7:0]               r_sum;
    logic [c_LW-1:0]          r_len_idx;
    logic [c_TW-1:0]          r_timer;
    logic                     r_ready;
    logic                     r_err;
    logic [8*INSTR_BYTES-1:0] r_script;
    logic [8*INSTR_BYTES-1:0] w_rd_word;
    logic [7:0]               mem [0:DEPTH-1];

    logic            w_frame;
    logic            w_header;
    logic            w_timeout;
    logic            w_last_len;
    logic [c_AW-1:0] w_size_new;
    logic [c_AW-1:0] w_cnt_inc;

    assign w_frame    = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_CHK);
    assign w_header   = bus.dataOut_valid && (bus.dataOut_bits[1:0] == 2'b10);
    // A byte in the same cycle as the expiry wins: the timeout needs an empty cycle.
    assign w_timeout  = w_frame && !bus.dataOut_valid && (r_timer == c_TW'(TIMEOUT_CYCLES - 1));
    assign w_last_len = (r_len_idx == c_LW'(LEN_BYTES - 1));
    assign w_size_new = c_AW'({r_size, bus.dataOut_bits});
    assign w_cnt_inc  = r_cnt + c_AW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_header) w_next = S_LEN;
            S_LEN: begin
                if (bus.dataOut_valid) begin
                    if (w_last_len) begin
                        if ({1'b0, w_size_new} > (c_AW + 1)'(DEPTH)) w_next = S_ERR;
                        else if (w_size_new == '0)                   w_next = S_CHK;
                        else                                         w_next = S_LOAD;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_LOAD: begin
                if (bus.dataOut_valid) begin
                    if (w_cnt_inc == r_size) w_next = S_CHK;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_CHK: begin
                if (bus.dataOut_valid) w_next = (bus.dataOut_bits == r_sum) ? S_DONE : S_ERR;
                else if (w_timeout)    w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_size    <= '0;
            r_cnt     <= '0;
            r_num     <= '0;
            r_sum     <= '0;
            r_len_idx <= '0;
            r_timer   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_script  <= '0;
        end else begin
            r_timer  <= (w_frame && !bus.dataOut_valid) ? r_timer + c_TW'(1) : '0;
            r_script <= w_rd_word;
            case (r_state)
                S_IDLE: begin
                    // The held script stops being valid as soon as a header arrives.
                    if (w_header) begin
                        r_ready   <= 1'b0;
                        r_sum     <= '0;
                        r_size    <= '0;
                        r_len_idx <= '0;
                    end
                end
                S_LEN: begin
                    if (bus.dataOut_valid) begin
                        r_size    <= w_size_new;
                        r_len_idx <= r_len_idx + c_LW'(1);
                        r_cnt     <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.dataOut_valid) begin
                        r_sum <= r_sum + bus.dataOut_bits;
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_err   <= 1'b0;
                    r_num   <= r_size;
                end
                S_ERR: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b1;
                    r_num   <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if ((r_state == S_LOAD) && bus.dataOut_valid) begin
            mem[r_cnt[c_MW-1:0]] <= bus.dataOut_bits;
        end
    end

    // One extra address bit so pc near the top never wraps back to low bytes.
    for (genvar i = 0; i < INSTR_BYTES; i++) begin : g_rd
        logic [c_AW:0] w_addr;
        assign w_addr = {1'b0, bus.pc} + (c_AW + 1)'(i);
        assign w_rd_word[8*(INSTR_BYTES-1-i) +: 8] =
            (r_ready && (w_addr < {1'b0, r_num})) ? mem[w_addr[c_MW-1:0]] : 8'h00;
    end

    assign bus.script       = w_frame ? '0 : r_script;
    assign bus.script_mode  = w_frame;
    assign bus.script_ready = r_ready;
    assign bus.load_error   = r_err;
    assign bus.script_num   = r_num;
endmodule
`default_nettype wire

// File: tb/tb_script_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_script_loader
// Random framed traffic against a queue-based frame model, plus literal checks.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_script_loader;
    localparam int DEPTH       = 255;
    localparam int LEN_BYTES   = 1;
    localparam int INSTR_BYTES = 2;
    localparam int TIMEOUT     = 40;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    script_loader_if #(.LEN_BYTES(LEN_BYTES), .INSTR_BYTES(INSTR_BYTES)) bus ();

    script_loader #(
        .DEPTH(DEPTH), .LEN_BYTES(LEN_BYTES),
        .INSTR_BYTES(INSTR_BYTES), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bytes after the header are queued and judged as a whole.
    logic [7:0]  m_img [0:255];
    logic [7:0]  m_q [$];
    int          m_need, m_idle, m_pending, m_size, m_num;
    bit          m_in_frame, m_ready, m_err;
    logic [15:0] m_script;

    task automatic model_reset();
        m_q.delete();
        m_need = -1; m_idle = 0; m_pending = 0; m_size = 0; m_num = 0;
        m_in_frame = 0; m_ready = 0; m_err = 0; m_script = '0;
    endtask

    task automatic model_step();
        logic [15:0] nxt;
        int a, sum;
        for (int i = 0; i < INSTR_BYTES; i++) begin
            a = int'(bus.pc) + i;
            nxt[8*(INSTR_BYTES-1-i) +: 8] = (m_ready && a < m_num) ? m_img[a] : 8'h00;
        end
        m_script = nxt;
        if (m_pending == 1) begin
            m_ready = 1; m_err = 0; m_num = m_size; m_pending = 0;
            for (int k = 0; k < m_size; k++) m_img[k] = m_q[LEN_BYTES + k];
        end else if (m_pending == 2) begin
            m_ready = 0; m_err = 1; m_num = 0; m_pending = 0;
        end else if (m_in_frame) begin
            if (bus.dataOut_valid) begin
                m_idle = 0;
                m_q.push_back(bus.dataOut_bits);
                if (m_q.size() == LEN_BYTES) begin
                    m_size = 0;
                    foreach (m_q[k]) m_size = m_size * 256 + int'(m_q[k]);
                    if (m_size > DEPTH) begin m_pending = 2; m_in_frame = 0; end
                    else m_need = LEN_BYTES + m_size + 1;
                end else if (m_q.size() == m_need) begin
                    sum = 0;
                    for (int k = 0; k < m_size; k++) sum += int'(m_q[LEN_BYTES + k]);
                    m_pending = ((sum % 256) == int'(m_q[m_need-1])) ? 1 : 2;
                    m_in_frame = 0;
                end
            end else begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin m_pending = 2; m_in_frame = 0; end
            end
        end else if (bus.dataOut_valid && bus.dataOut_bits[1:0] == 2'b10) begin
            m_in_frame = 1; m_q.delete(); m_need = -1; m_idle = 0; m_ready = 0;
        end
    endtask

    // Inputs are stable at the falling edge and are what the next rising edge samples.
    always @(negedge clock) begin
        if (!reset_n) model_reset();
        if (started) begin
            check("mode",   bus.script_mode,  32'(m_in_frame));
            check("ready",  bus.script_ready, 32'(m_ready));
            check("error",  bus.load_error,   32'(m_err));
            check("num",    bus.script_num,   32'(m_num));
            check("script", bus.script,       m_in_frame ? 32'h0 : 32'(m_script));
        end
        if (reset_n) model_step();
    end

    function automatic logic [7:0] rand_pc();
        return 8'($urandom_range(0, 24));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.dataOut_valid = 1'b0;
            bus.pc = rand_pc();
            @(posedge clock); #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.dataOut_valid = 1'b1;
        bus.dataOut_bits  = b;
        bus.pc = rand_pc();
        @(posedge clock); #1;
        bus.dataOut_valid = 1'b0;
    endtask

    task automatic read_at(input logic [7:0] p, input logic [15:0] exp, input string name);
        bus.dataOut_valid = 1'b0;
        bus.pc = p;
        @(posedge clock); #1;
        check(name, bus.script, 32'(exp));
    endtask

    function automatic int rand_gap();
        return ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
    endfunction

    // kind: 0 good, 1 bad checksum, 2 truncated (ends in a timeout)
    task automatic rand_frame(input int kind);
        int n, sum, cut;
        logic [7:0] b;
        n = $urandom_range(0, 20);
        cut = $urandom_range(0, n);
        sum = 0;
        b = 8'($urandom);
        send({b[7:2], 2'b10});
        idle(rand_gap());
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            if (kind == 2 && i == cut) begin idle(TIMEOUT + 2); return; end
            idle(rand_gap());
            b = 8'($urandom);
            sum += int'(b);
            send(b);
        end
        if (kind == 2) begin idle(TIMEOUT + 2); return; end
        idle(rand_gap());
        send((kind == 1) ? 8'(sum + 1 + $urandom_range(0, 254)) : 8'(sum));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bus.dataOut_valid = 1'b0;
        bus.dataOut_bits  = 8'h00;
        bus.pc            = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        started = 1'b1;
        check("rst ready",  bus.script_ready, 0);
        check("rst error",  bus.load_error,   0);
        check("rst num",    bus.script_num,   0);
        check("rst mode",   bus.script_mode,  0);
        check("rst script", bus.script,       0);
        reset_n = 1'b1;
        idle(2);

        // Good 3-byte script and reads across its end
        send(8'h02);
        check("t1 mode in frame", bus.script_mode, 1);
        check("t1 script in frame", bus.script, 0);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        idle(1);
        check("t1 ready", bus.script_ready, 1);
        check("t1 num", bus.script_num, 3);
        read_at(8'd0, 16'h1122, "t1 pc0");
        read_at(8'd2, 16'h3300, "t1 pc2");
        read_at(8'd3, 16'h0000, "t1 pc3");

        // Bad checksum
        send(8'h02); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
        idle(1);
        check("t2 error", bus.load_error, 1);
        check("t2 ready", bus.script_ready, 0);
        read_at(8'd0, 16'h0000, "t2 pc0");
        read_at(8'd1, 16'h0000, "t2 pc1");

        // Non-header byte in idle
        send(8'h05);
        check("t5 noise ignored", bus.script_mode, 0);
        idle(1);

        // Full-depth script, then an empty one
        send(8'h02); send(8'hFF);
        for (int i = 0; i < 255; i++) send(8'h01);
        send(8'hFF);
        idle(1);
        check("t3 ready", bus.script_ready, 1);
        check("t3 num", bus.script_num, 255);
        read_at(8'd253, 16'h0101, "t3 pc253");
        read_at(8'd254, 16'h0100, "t3 pc254");
        read_at(8'd255, 16'h0000, "t3 pc255");
        send(8'h02); send(8'h00); send(8'h00);
        idle(1);
        check("t3 empty ready", bus.script_ready, 1);
        check("t3 empty num", bus.script_num, 0);
        read_at(8'd0, 16'h0000, "t3 empty pc0");

        // Timeout mid-load, then recovery
        send(8'h02); send(8'h04); send(8'h01); send(8'h02);
        idle(TIMEOUT - 1);
        check("t4 mode before expiry", bus.script_mode, 1);
        idle(2);
        check("t4 error", bus.load_error, 1);
        check("t4 mode", bus.script_mode, 0);
        send(8'h02); send(8'h02); send(8'h10); send(8'h20); send(8'h30);
        idle(1);
        check("t4 error cleared", bus.load_error, 0);
        check("t4 num", bus.script_num, 2);
        read_at(8'd0, 16'h1020, "t4 pc0");

        // Bytes landing on the expiry cycle keep the frame alive
        send(8'h02); send(8'h03); send(8'h01);
        idle(TIMEOUT - 1); send(8'h02);
        idle(TIMEOUT - 1); send(8'h03);
        idle(TIMEOUT - 1);
        check("t6 still loading", bus.script_mode, 1);
        send(8'h06);
        idle(1);
        check("t6 error", bus.load_error, 0);
        check("t6 ready", bus.script_ready, 1);
        check("t6 num", bus.script_num, 3);

        // Reset mid-load
        send(8'h02); send(8'h05); send(8'h01); send(8'h02);
        reset_n = 1'b0;
        #1;
        check("t5 rst num", bus.script_num, 0);
        check("t5 rst mode", bus.script_mode, 0);
        check("t5 rst ready", bus.script_ready, 0);
        check("t5 rst error", bus.load_error, 0);
        check("t5 rst script", bus.script, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(2);

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rand_frame(0);
                6: rand_frame(1);
                7: rand_frame(2);
                8: begin
                    for (int k = 0; k < 3; k++) begin
                        b = 8'($urandom);
                        if (b[1:0] == 2'b10) b[0] = 1'b1;
                        send(b);
                    end
                end
                default: idle($urandom_range(1, 6));
            endcase
            idle($urandom_range(1, 4));
        end
        idle(TIMEOUT + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
